// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio output path.
//   SAMPLE_W    - sample width and I2S channel slot width
//   FRAME_SLOTS - BCLK periods per I2S frame (left + right slots)
//   sample_t    - one mono audio sample
//   i2s_state_t - transmitter run state
package audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides CLK down to the I2S bit clock.
//   CLK      in   system clock
//   RESET_N  in   asynchronous active-low reset
//   run      in   count while high; divider and BCLK held at 0 while low
//   BCLK     out  registered bit clock, period 2*BCLK_DIV CLK cycles
//   fall_evt out  high for the CLK cycle whose rising edge drives BCLK 1->0
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic run,
  output logic BCLK,
  output logic fall_evt
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0] div_r;
  logic       bclk_r;
  logic       tc_s;

  assign tc_s     = (div_r == DIV_LAST);
  // The fall event is announced in the same cycle the register toggles, so
  // the consumer's registers update on the same CLK edge as BCLK.
  assign fall_evt = run & tc_s & bclk_r;
  assign BCLK     = bclk_r;

  // Half-period divider and bit clock register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_r  <= 8'd0;
      bclk_r <= 1'b0;
    end else if (!run) begin
      div_r  <= 8'd0;
      bclk_r <= 1'b0;
    end else if (tc_s) begin
      div_r  <= 8'd0;
      bclk_r <= ~bclk_r;
    end else begin
      div_r  <= div_r + 8'd1;
      bclk_r <= bclk_r;
    end
  end

endmodule

// File: rtl/i2s_tx_16.sv
// i2s_tx_16: I2S transmitter for 16-bit mono samples. Each sample read from
// the FIFO is sent on both left and right channels, MSB first, with the
// standard one-bit delay after LRCLK changes. One FIFO read per frame.
//   CLK        in   system clock
//   RESET_N    in   asynchronous active-low reset
//   ENABLE     in   run request, honoured only at frame boundaries
//   FIFO_EMPTY in   FIFO has no word available
//   FIFO_DATA  in   FIFO read data, valid the cycle after FIFO_RD
//   FIFO_RD    out  single-cycle read strobe
//   BCLK       out  I2S bit clock
//   LRCLK      out  word select, 0 = left, 1 = right
//   SDATA      out  serial data
//   UNDERRUN   out  single-cycle pulse when a fetch finds the FIFO empty
module i2s_tx_16 #(
  parameter int BCLK_DIV = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                ENABLE,
  input  logic                FIFO_EMPTY,
  input  logic [SAMPLE_W-1:0] FIFO_DATA,
  output logic                FIFO_RD,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                SDATA,
  output logic                UNDERRUN
);

  import audio_pkg::*;

  localparam int         SHIFT_W    = 2 * SAMPLE_W;
  localparam logic [4:0] SLOT_LAST  = 5'(FRAME_SLOTS - 1);
  // Entering this slot's successor (slot 16) fetches the next frame's sample.
  localparam logic [4:0] SLOT_FETCH = 5'(SAMPLE_W - 1);

  i2s_state_t          state_r;
  logic [4:0]          slot_r;
  logic [4:0]          slot_next_s;
  logic [SAMPLE_W-1:0] hold_r;
  logic [SHIFT_W-1:0]  shift_r;
  logic [SHIFT_W-1:0]  shift_next_s;
  logic                rd_r;
  logic                cap_pend_r;
  logic                underrun_r;
  logic                lrclk_r;
  logic                sdata_r;
  logic                stop_r;
  logic                run_s;
  logic                fall_s;
  logic                fetch_s;

  assign run_s = (state_r == RUN);

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .run      (run_s),
    .BCLK     (BCLK),
    .fall_evt (fall_s)
  );

  // Next slot number and next shift register contents for a fall event.
  always_comb begin
    slot_next_s  = slot_r + 5'd1;
    shift_next_s = {shift_r[SHIFT_W-2:0], 1'b0};
    if (slot_r == SLOT_LAST) begin
      slot_next_s = 5'd0;
    end else begin
      slot_next_s = slot_r + 5'd1;
    end
    // Loading on entry to slot 1 gives the one-bit delay after LRCLK falls.
    if (slot_r == 5'd0) begin
      shift_next_s = {hold_r, hold_r};
    end else begin
      shift_next_s = {shift_r[SHIFT_W-2:0], 1'b0};
    end
  end

  // Fetch request: on run start, and on the event entering slot 16.
  always_comb begin
    fetch_s = 1'b0;
    case (state_r)
      IDLE:    fetch_s = ENABLE;
      RUN:     fetch_s = fall_s & (slot_r == SLOT_FETCH);
      default: fetch_s = 1'b0;
    endcase
  end

  // Run-state FSM with fetch/hold, slot counter and serializer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= IDLE;
      slot_r     <= 5'd0;
      hold_r     <= {SAMPLE_W{1'b0}};
      shift_r    <= {SHIFT_W{1'b0}};
      rd_r       <= 1'b0;
      cap_pend_r <= 1'b0;
      underrun_r <= 1'b0;
      lrclk_r    <= 1'b0;
      sdata_r    <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      rd_r       <= 1'b0;
      underrun_r <= 1'b0;
      // FIFO returns data the cycle after the strobe; capture it then.
      cap_pend_r <= rd_r;
      if (cap_pend_r) begin
        hold_r <= FIFO_DATA;
      end
      if (fetch_s) begin
        if (FIFO_EMPTY) begin
          hold_r     <= {SAMPLE_W{1'b0}};
          underrun_r <= 1'b1;
        end else begin
          rd_r <= 1'b1;
        end
      end
      case (state_r)
        IDLE: begin
          if (ENABLE) begin
            state_r <= RUN;
            slot_r  <= 5'd0;
            shift_r <= {SHIFT_W{1'b0}};
            lrclk_r <= 1'b0;
            sdata_r <= 1'b0;
            stop_r  <= 1'b0;
          end
        end
        RUN: begin
          if (fall_s) begin
            if (stop_r) begin
              // Slot 0 (right LSB) has completed; park everything at zero.
              state_r <= IDLE;
              slot_r  <= 5'd0;
              shift_r <= {SHIFT_W{1'b0}};
              lrclk_r <= 1'b0;
              sdata_r <= 1'b0;
              stop_r  <= 1'b0;
            end else begin
              slot_r  <= slot_next_s;
              lrclk_r <= slot_next_s[4];
              shift_r <= shift_next_s;
              sdata_r <= shift_next_s[SHIFT_W-1];
              // ENABLE is only looked at on the frame boundary.
              if (slot_next_s == 5'd0) begin
                stop_r <= ~ENABLE;
              end
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign FIFO_RD  = rd_r;
  assign UNDERRUN = underrun_r;
  assign LRCLK    = lrclk_r;
  assign SDATA    = sdata_r;

endmodule

// File: tb/tb_i2s_tx_16.sv
// tb_i2s_tx_16: self-checking bench for i2s_tx_16 with BCLK_DIV=2.
// A FIFO model feeds the DUT; a monitor records {LRCLK,SDATA} at every BCLK
// rise plus the cycle of every FIFO_RD and UNDERRUN pulse. After each run the
// recorded bit stream is decoded as I2S frames and compared with the samples
// the bench queued.
module tb_i2s_tx_16;

  localparam int DIV   = 2;
  localparam int FRAME = 64 * DIV;

  logic        CLK        = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        ENABLE     = 1'b0;
  logic        FIFO_EMPTY = 1'b1;
  logic [15:0] FIFO_DATA  = 16'h0000;
  logic        FIFO_RD;
  logic        BCLK;
  logic        LRCLK;
  logic        SDATA;
  logic        UNDERRUN;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int en       = 0;
  int both_cnt = 0;
  logic force_empty = 1'b0;
  logic bclk_prev   = 1'b0;

  logic [15:0] fifo_q[$];
  logic [1:0]  bits_q[$];
  int          rise_q[$];
  int          rd_q[$];
  int          ur_q[$];
  int          exp_rd[$];
  int          exp_ur[$];
  logic [15:0] exp_w[$];
  logic [15:0] w0, w1, w2, w3;

  i2s_tx_16 #(
    .BCLK_DIV (DIV),
    .SAMPLE_W (16)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_DATA  (FIFO_DATA),
    .FIFO_RD    (FIFO_RD),
    .BCLK       (BCLK),
    .LRCLK      (LRCLK),
    .SDATA      (SDATA),
    .UNDERRUN   (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  // Cycle counter and FIFO read port.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (FIFO_RD === 1'b1 && fifo_q.size() > 0) FIFO_DATA <= fifo_q.pop_front();
  end

  // FIFO flag update and output monitor, away from the active edge.
  always @(negedge CLK) begin
    FIFO_EMPTY = force_empty || (fifo_q.size() == 0);
    if (BCLK === 1'b1 && bclk_prev === 1'b0) begin
      bits_q.push_back({LRCLK, SDATA});
      rise_q.push_back(cyc);
    end
    bclk_prev = BCLK;
    if (FIFO_RD === 1'b1) rd_q.push_back(cyc);
    if (UNDERRUN === 1'b1) ur_q.push_back(cyc);
    if (FIFO_RD === 1'b1 && UNDERRUN === 1'b1) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_mon();
    bits_q.delete(); rise_q.delete(); rd_q.delete(); ur_q.delete();
    exp_rd.delete(); exp_ur.delete(); exp_w.delete();
    both_cnt = 0;
  endtask

  task automatic start_run();
    @(posedge CLK);
    #1;
    ENABLE = 1'b1;
    en = cyc;
  endtask

  // Drop ENABLE at slot 5 of the last frame, then wait until well past idle.
  task automatic finish_run(input int n);
    wait_until(en + 1 + FRAME * (n - 1) + 20);
    ENABLE = 1'b0;
    wait_until(en + 1 + FRAME * n + 40);
  endtask

  // Fetch k: k=0 at run start, k>=1 at slot 16 of frame k-1.
  function automatic int fetch_cyc(input int k);
    if (k == 0) return en + 1;
    else return en + 1 + FRAME / 2 + FRAME * (k - 1);
  endfunction

  function automatic logic [15:0] dec(input int s);
    logic [15:0] w;
    w = 16'h0000;
    for (int k = 0; k < 16; k++) w = {w[14:0], bits_q[s + k][0]};
    return w;
  endfunction

  task automatic check_run(input int n);
    int lr_bad;
    chk("bit_count", bits_q.size(), 32 * n + 1);
    if (bits_q.size() == 32 * n + 1) begin
      for (int f = 0; f < n; f++) begin
        chk("left_word", {16'd0, dec(32 * f + 1)}, {16'd0, exp_w[f]});
        chk("right_word", {16'd0, dec(32 * f + 17)}, {16'd0, exp_w[f]});
      end
      lr_bad = 0;
      for (int i = 0; i < bits_q.size(); i++)
        if (bits_q[i][1] !== ((i % 32) >= 16)) lr_bad++;
      chk("lrclk_pattern", lr_bad, 0);
      chk("first_bclk_rise", rise_q[0], en + 1 + DIV);
      chk("frame_period", rise_q[32 * n] - rise_q[0], FRAME * n);
    end
    chk("rd_count", rd_q.size(), exp_rd.size());
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) chk("rd_cycle", rd_q[i], exp_rd[i]);
    chk("ur_count", ur_q.size(), exp_ur.size());
    for (int i = 0; i < ur_q.size() && i < exp_ur.size(); i++) chk("ur_cycle", ur_q[i], exp_ur[i]);
    chk("rd_ur_overlap", both_cnt, 0);
    chk("idle_outputs", {27'd0, BCLK, LRCLK, SDATA, FIFO_RD, UNDERRUN}, 32'd0);
  endtask

  initial begin
    // Reset values, then no read on release while ENABLE is low.
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_bclk", {31'd0, BCLK}, 32'd0);
    chk("reset_lrclk", {31'd0, LRCLK}, 32'd0);
    chk("reset_sdata", {31'd0, SDATA}, 32'd0);
    chk("reset_fifo_rd", {31'd0, FIFO_RD}, 32'd0);
    chk("reset_underrun", {31'd0, UNDERRUN}, 32'd0);
    clear_mon();
    RESET_N = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    chk("release_no_rd", rd_q.size(), 0);
    chk("release_no_bclk", rise_q.size(), 0);

    // Single frame of 0xA5C3.
    clear_mon();
    fifo_q.delete();
    fifo_q.push_back(16'hA5C3);
    fifo_q.push_back(16'($urandom));
    start_run();
    exp_w.push_back(16'hA5C3);
    exp_rd.push_back(fetch_cyc(0));
    exp_rd.push_back(fetch_cyc(1));
    finish_run(1);
    check_run(1);

    // Empty FIFO: zeros and an underrun at every fetch.
    clear_mon();
    fifo_q.delete();
    start_run();
    for (int f = 0; f < 2; f++) exp_w.push_back(16'h0000);
    for (int k = 0; k < 3; k++) exp_ur.push_back(fetch_cyc(k));
    finish_run(2);
    check_run(2);

    // Sequential samples including both extremes.
    clear_mon();
    fifo_q.delete();
    fifo_q.push_back(16'h0001);
    fifo_q.push_back(16'h8000);
    fifo_q.push_back(16'hFFFF);
    fifo_q.push_back(16'($urandom));
    start_run();
    exp_w.push_back(16'h0001);
    exp_w.push_back(16'h8000);
    exp_w.push_back(16'hFFFF);
    for (int k = 0; k < 4; k++) exp_rd.push_back(fetch_cyc(k));
    finish_run(3);
    check_run(3);

    // Underrun on the second frame only, random data around it.
    clear_mon();
    fifo_q.delete();
    w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    fifo_q.push_back(w2);
    start_run();
    exp_w.push_back(w0);
    exp_w.push_back(16'h0000);
    exp_w.push_back(w1);
    exp_rd.push_back(fetch_cyc(0));
    exp_ur.push_back(fetch_cyc(1));
    exp_rd.push_back(fetch_cyc(2));
    exp_rd.push_back(fetch_cyc(3));
    wait_until(en + 40);
    force_empty = 1'b1;
    wait_until(en + 100);
    force_empty = 1'b0;
    finish_run(3);
    check_run(3);

    // Asynchronous reset in slot 20, restart with ENABLE held high.
    clear_mon();
    fifo_q.delete();
    w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom); w3 = 16'($urandom);
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    start_run();
    wait_until(en + 1 + 20 * 2 * DIV + 2);
    chk("pre_reset_lrclk", {31'd0, LRCLK}, 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("async_reset_outputs", {27'd0, BCLK, LRCLK, SDATA, FIFO_RD, UNDERRUN}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    clear_mon();
    fifo_q.delete();
    fifo_q.push_back(w2);
    fifo_q.push_back(w3);
    RESET_N = 1'b1;
    en = cyc;
    exp_w.push_back(w2);
    exp_rd.push_back(fetch_cyc(0));
    exp_rd.push_back(fetch_cyc(1));
    finish_run(1);
    check_run(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
